// File: rtl/inst_buffer.sv
// inst_buffer: circular FIFO between fetch-check and decode.
// Each entry is {excp_num[3:0], excp, vaddr[31:0], inst[31:0]} (69 bits).
// Any of flush / excp_flush / ertn_flush empties the buffer and blocks both
// handshakes for that cycle.
// Optional feature macro: IB_BYPASS_EN. When it is defined, an empty buffer
// presents the incoming entry to decode in the same cycle. When it is
// undefined, an entry reaches decode one cycle after it is written.
module inst_buffer #(
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             excp_flush,
  input  logic             ertn_flush,
  input  logic             ib_valid,
  output logic             ib_ready,
  output logic             fire,
  input  logic [31:0]      inst_i,
  input  logic [31:0]      vaddr_i,
  input  logic             excp_i,
  input  logic [3:0]       excp_num_i,
  output logic             id_valid,
  input  logic             id_ready,
  output logic [31:0]      inst_o,
  output logic [31:0]      pc_o,
  output logic             excp_o,
  output logic [3:0]       excp_num_o,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ZERO = {(PTR_W + 1){1'b0}};
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [68:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;

  logic        kill_s;
  logic        full_s;
  logic        empty_s;
  logic        ib_ready_s;
  logic        push_s;
  logic        pop_s;
  logic        wr_en_s;
  logic        id_valid_s;
  logic [68:0] in_data_s;
  logic [68:0] rd_data_s;
  logic [68:0] head_s;
`ifdef IB_BYPASS_EN
  logic        bypass_s;
`endif

  assign in_data_s = {excp_num_i, excp_i, vaddr_i, inst_i};

  // Handshake decode: kill masks both sides; a full buffer refuses pushes
  // even when a pop happens in the same cycle, so ib_ready does not depend on id_ready.
  always_comb begin
    kill_s     = flush | excp_flush | ertn_flush;
    full_s     = (cnt_q == CNT_FULL);
    empty_s    = (cnt_q == CNT_ZERO);
    rd_data_s  = mem_q[rd_ptr_q];
    ib_ready_s = !kill_s && !full_s;
    push_s     = ib_valid && ib_ready_s;
`ifdef IB_BYPASS_EN
    bypass_s   = !kill_s && empty_s && ib_valid;
    if (bypass_s) begin
      head_s = in_data_s;
    end else begin
      head_s = rd_data_s;
    end
    id_valid_s = !kill_s && (!empty_s || ib_valid);
    pop_s      = id_valid_s && id_ready && !empty_s;
    // A bypassed entry that decode takes immediately is never stored.
    wr_en_s    = push_s && !(bypass_s && id_ready);
`else
    head_s     = rd_data_s;
    id_valid_s = !kill_s && !empty_s;
    pop_s      = id_valid_s && id_ready;
    wr_en_s    = push_s;
`endif
  end

  // Next pointer and occupancy state: kill empties the buffer and takes priority over push and pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (kill_s) begin
      wr_ptr_d = PTR_ZERO;
      rd_ptr_d = PTR_ZERO;
      cnt_d    = CNT_ZERO;
    end else begin
      if (wr_en_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({wr_en_s, pop_s})
        2'b10:   cnt_d = cnt_q + CNT_ONE;
        2'b01:   cnt_d = cnt_q - CNT_ONE;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Pointer and occupancy registers, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= PTR_ZERO;
      rd_ptr_q <= PTR_ZERO;
      cnt_q    <= CNT_ZERO;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Entry storage. It has no reset because the head is ignored while id_valid is low.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q] <= in_data_s;
    end
  end

  assign ib_ready   = ib_ready_s;
  assign fire       = push_s;
  assign id_valid   = id_valid_s;
  assign inst_o     = head_s[31:0];
  assign pc_o       = head_s[63:32];
  assign excp_o     = head_s[64];
  assign excp_num_o = head_s[68:65];
  assign count      = cnt_q;

endmodule
